// File: rtl/retire_trace_serializer_if.sv
// Bus bundle for retire_trace_serializer: parallel retire ports in, serialized record stream out.
// out_time_o exists only when TRACE_TIMESTAMP_EN is defined.
interface retire_trace_serializer_if #(
    parameter int NUM_PORTS = 3,
    parameter int DEPTH     = 16
);
    localparam int REC_W  = 175;
    localparam int PORT_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int LVL_W  = $clog2(DEPTH) + 1;

    logic [NUM_PORTS-1:0]       valid_i;
    logic [NUM_PORTS*REC_W-1:0] rec_i;
    logic                       in_ready_o;
    logic                       out_valid_o;
    logic                       out_ready_i;
    logic [REC_W-1:0]           out_rec_o;
    logic [PORT_W-1:0]          out_port_o;
    logic [31:0]                out_seq_o;
`ifdef TRACE_TIMESTAMP_EN
    logic [31:0]                out_time_o;
`endif
    logic [LVL_W-1:0]           level_o;
    logic                       overflow_o;
    logic [15:0]                drop_cnt_o;

    modport slave (
`ifdef TRACE_TIMESTAMP_EN
        output out_time_o,
`endif
        input  valid_i, rec_i, out_ready_i,
        output in_ready_o, out_valid_o, out_rec_o, out_port_o, out_seq_o,
        output level_o, overflow_o, drop_cnt_o
    );

    modport master (
`ifdef TRACE_TIMESTAMP_EN
        input  out_time_o,
`endif
        output valid_i, rec_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_rec_o, out_port_o, out_seq_o,
        input  level_o, overflow_o, drop_cnt_o
    );
endinterface

// File: rtl/retire_trace_serializer.sv
// Multi-port retire trace collector: compacts up to NUM_PORTS records per cycle into a FIFO,
// all-or-nothing acceptance. Optional per-record cycle stamp under TRACE_TIMESTAMP_EN.
module retire_trace_serializer #(
    parameter int NUM_PORTS = 3,
    parameter int DEPTH     = 16
) (
    input logic                   clk_i,
    input logic                   reset_i,
    retire_trace_serializer_if.slave bus
);
    localparam int REC_W  = 175;
    localparam int PORT_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int LVL_W  = PTR_W + 1;

    logic [REC_W-1:0]  rec_mem  [DEPTH];
    logic [PORT_W-1:0] port_mem [DEPTH];
    logic [31:0]       seq_mem  [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic [31:0]      seq_q, seq_d;
    logic             overflow_q, overflow_d;
    logic [15:0]      drop_cnt_q, drop_cnt_d;

    logic [LVL_W-1:0] off [NUM_PORTS];
    logic [PTR_W-1:0] wr_idx [NUM_PORTS];
    logic [LVL_W-1:0] pcnt, free_slots, push_n;
    logic             accept, pop;
    logic [16:0]      drop_sum;

`ifdef TRACE_TIMESTAMP_EN
    logic [31:0] time_mem [DEPTH];
    logic [31:0] cyc_q, cyc_d;
`endif

    always_comb begin
        pcnt = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            off[k]    = pcnt;
            wr_idx[k] = wr_ptr_q + off[k][PTR_W-1:0];
            pcnt      = pcnt + LVL_W'(bus.valid_i[k]);
        end
        // Free space is taken before any pop, so a slot freed this cycle is not reusable yet.
        free_slots = LVL_W'(DEPTH) - level_q;
        accept     = (pcnt <= free_slots);
        pop        = (level_q != '0) && bus.out_ready_i;
        push_n     = accept ? pcnt : '0;
        level_d    = level_q + push_n - LVL_W'(pop);
        wr_ptr_d   = wr_ptr_q + push_n[PTR_W-1:0];
        rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
        seq_d      = seq_q + 32'(push_n);
        drop_sum   = {1'b0, drop_cnt_q} + 17'(pcnt);
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        if (!accept) begin
            overflow_d = 1'b1;
            drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
`ifdef TRACE_TIMESTAMP_EN
        cyc_d = cyc_q + 32'd1;
`endif
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            seq_q      <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            seq_q      <= seq_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

`ifdef TRACE_TIMESTAMP_EN
    always_ff @(posedge clk_i) begin
        if (reset_i) cyc_q <= '0;
        else         cyc_q <= cyc_d;
    end
`endif

    // Storage is deliberately not reset; head contents are meaningless while empty.
    always_ff @(posedge clk_i) begin
        if (!reset_i && accept) begin
            for (int k = 0; k < NUM_PORTS; k++) begin
                if (bus.valid_i[k]) begin
                    rec_mem[wr_idx[k]]  <= bus.rec_i[k*REC_W +: REC_W];
                    port_mem[wr_idx[k]] <= PORT_W'(k);
                    seq_mem[wr_idx[k]]  <= seq_q + 32'(off[k]);
`ifdef TRACE_TIMESTAMP_EN
                    time_mem[wr_idx[k]] <= cyc_q;
`endif
                end
            end
        end
    end

    assign bus.out_valid_o = (level_q != '0);
    assign bus.in_ready_o  = (free_slots >= LVL_W'(NUM_PORTS));
    assign bus.out_rec_o   = rec_mem[rd_ptr_q];
    assign bus.out_port_o  = port_mem[rd_ptr_q];
    assign bus.out_seq_o   = seq_mem[rd_ptr_q];
`ifdef TRACE_TIMESTAMP_EN
    assign bus.out_time_o  = time_mem[rd_ptr_q];
`endif
    assign bus.level_o     = level_q;
    assign bus.overflow_o  = overflow_q;
    assign bus.drop_cnt_o  = drop_cnt_q;
endmodule

// File: tb/tb_retire_trace_serializer.sv
// Directed bench for retire_trace_serializer (NUM_PORTS=3, DEPTH=16).
// Timestamp checks run only when TRACE_TIMESTAMP_EN is defined.
module tb_retire_trace_serializer;
    localparam int REC_W = 175;

    logic clk;
    logic reset_i;
    int   n_cmp;
    int   n_bad;

    retire_trace_serializer_if #(.NUM_PORTS(3), .DEPTH(16)) bus ();

    retire_trace_serializer #(.NUM_PORTS(3), .DEPTH(16)) dut (
        .clk_i   (clk),
        .reset_i (reset_i),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [REC_W-1:0] mk_rec(input logic [31:0] pc);
        logic [REC_W-1:0] r;
        r          = '0;
        r[31:0]    = pc;
        r[63:32]   = ~pc;
        r[174:170] = pc[4:0];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(input int k, input logic [31:0] pc);
        bus.rec_i[k*REC_W +: REC_W] = mk_rec(pc);
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        n_cmp++; if (bus.level_o !== 5'd0) begin n_bad++; $display("FAIL reset_level got %0d exp 0", bus.level_o); end
        n_cmp++; if (bus.out_valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b exp 0", bus.out_valid_o); end
        n_cmp++; if (bus.in_ready_o !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %b exp 1", bus.in_ready_o); end
        n_cmp++; if (bus.overflow_o !== 1'b0) begin n_bad++; $display("FAIL reset_overflow got %b exp 0", bus.overflow_o); end
        n_cmp++; if (bus.drop_cnt_o !== 16'd0) begin n_bad++; $display("FAIL reset_drop_cnt got %0d exp 0", bus.drop_cnt_o); end
    endtask

    task automatic test_basic();
        bus.out_ready_i = 1'b1;
        bus.valid_i     = 3'b101;
        set_port(0, 32'h100);
        set_port(1, 32'hDEAD);
        set_port(2, 32'h108);
        tick();
        bus.valid_i = 3'b000;
        n_cmp++; if (bus.out_valid_o !== 1'b1) begin n_bad++; $display("FAIL basic_valid0 got %b exp 1", bus.out_valid_o); end
        n_cmp++; if (bus.out_port_o !== 2'd0) begin n_bad++; $display("FAIL basic_port0 got %0d exp 0", bus.out_port_o); end
        n_cmp++; if (bus.out_seq_o !== 32'd0) begin n_bad++; $display("FAIL basic_seq0 got %0d exp 0", bus.out_seq_o); end
        n_cmp++; if (bus.out_rec_o !== mk_rec(32'h100)) begin n_bad++; $display("FAIL basic_rec0 got pc %h exp 100", bus.out_rec_o[31:0]); end
        tick();
        n_cmp++; if (bus.out_port_o !== 2'd2) begin n_bad++; $display("FAIL basic_port1 got %0d exp 2", bus.out_port_o); end
        n_cmp++; if (bus.out_seq_o !== 32'd1) begin n_bad++; $display("FAIL basic_seq1 got %0d exp 1", bus.out_seq_o); end
        n_cmp++; if (bus.out_rec_o !== mk_rec(32'h108)) begin n_bad++; $display("FAIL basic_rec1 got pc %h exp 108", bus.out_rec_o[31:0]); end
        tick();
        n_cmp++; if (bus.out_valid_o !== 1'b0) begin n_bad++; $display("FAIL basic_drained got %b exp 0", bus.out_valid_o); end
    endtask

    // Seq counter is 2 on entry; fills 15 entries then drops a 3-wide burst.
    task automatic test_overflow();
        bus.out_ready_i = 1'b0;
        bus.valid_i     = 3'b111;
        for (int c = 1; c <= 6; c++) begin
            for (int k = 0; k < 3; k++) set_port(k, 32'h1000 + 32'(c*16 + k*4));
            tick();
            if (c <= 5) begin
                n_cmp++; if (bus.level_o !== 5'(3*c)) begin n_bad++; $display("FAIL ovf_level_c%0d got %0d exp %0d", c, bus.level_o, 3*c); end
                n_cmp++; if (bus.in_ready_o !== (3*c <= 13)) begin n_bad++; $display("FAIL ovf_in_ready_c%0d got %b exp %b", c, bus.in_ready_o, (3*c <= 13)); end
            end
        end
        bus.valid_i = 3'b000;
        n_cmp++; if (bus.level_o !== 5'd15) begin n_bad++; $display("FAIL ovf_level_final got %0d exp 15", bus.level_o); end
        n_cmp++; if (bus.overflow_o !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky got %b exp 1", bus.overflow_o); end
        n_cmp++; if (bus.drop_cnt_o !== 16'd3) begin n_bad++; $display("FAIL ovf_drop_cnt got %0d exp 3", bus.drop_cnt_o); end
        n_cmp++; if (bus.in_ready_o !== 1'b0) begin n_bad++; $display("FAIL ovf_in_ready_final got %b exp 0", bus.in_ready_o); end
        n_cmp++; if (bus.out_seq_o !== 32'd2) begin n_bad++; $display("FAIL ovf_head_stable_seq got %0d exp 2", bus.out_seq_o); end
        n_cmp++; if (bus.out_rec_o !== mk_rec(32'h1010)) begin n_bad++; $display("FAIL ovf_head_stable_rec got pc %h exp 1010", bus.out_rec_o[31:0]); end
    endtask

    task automatic test_full_pop();
        logic [31:0] es;
        logic [1:0]  ep;
        bus.valid_i = 3'b001;
        set_port(0, 32'h2000);
        tick();
        n_cmp++; if (bus.level_o !== 5'd16) begin n_bad++; $display("FAIL full_level got %0d exp 16", bus.level_o); end
        bus.out_ready_i = 1'b1;
        set_port(0, 32'h2004);
        tick();
        bus.valid_i = 3'b000;
        n_cmp++; if (bus.level_o !== 5'd15) begin n_bad++; $display("FAIL full_pop_level got %0d exp 15", bus.level_o); end
        n_cmp++; if (bus.drop_cnt_o !== 16'd4) begin n_bad++; $display("FAIL full_pop_drop got %0d exp 4", bus.drop_cnt_o); end
        for (int i = 0; i < 15; i++) begin
            es = 32'(3 + i);
            ep = (es == 32'd17) ? 2'd0 : 2'((es - 32'd2) % 32'd3);
            n_cmp++; if (bus.out_seq_o !== es) begin n_bad++; $display("FAIL drain_seq_%0d got %0d exp %0d", i, bus.out_seq_o, es); end
            n_cmp++; if (bus.out_port_o !== ep) begin n_bad++; $display("FAIL drain_port_%0d got %0d exp %0d", i, bus.out_port_o, ep); end
            tick();
        end
        n_cmp++; if (bus.level_o !== 5'd0) begin n_bad++; $display("FAIL drain_empty got %0d exp 0", bus.level_o); end
        tick();
        n_cmp++; if (bus.level_o !== 5'd0) begin n_bad++; $display("FAIL pop_on_empty got %0d exp 0", bus.level_o); end
        n_cmp++; if (bus.out_valid_o !== 1'b0) begin n_bad++; $display("FAIL pop_on_empty_valid got %b exp 0", bus.out_valid_o); end
    endtask

    task automatic test_seq_wrap();
        bus.out_ready_i = 1'b1;
        bus.valid_i     = 3'b011;
        set_port(0, 32'h300);
        set_port(1, 32'h304);
        force dut.seq_q = 32'hFFFF_FFFF;
        tick();
        release dut.seq_q;
        bus.valid_i = 3'b000;
        n_cmp++; if (bus.out_seq_o !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL wrap_seq0 got %h exp ffffffff", bus.out_seq_o); end
        n_cmp++; if (bus.out_port_o !== 2'd0) begin n_bad++; $display("FAIL wrap_port0 got %0d exp 0", bus.out_port_o); end
        tick();
        n_cmp++; if (bus.out_seq_o !== 32'h0) begin n_bad++; $display("FAIL wrap_seq1 got %h exp 00000000", bus.out_seq_o); end
        n_cmp++; if (bus.out_rec_o !== mk_rec(32'h304)) begin n_bad++; $display("FAIL wrap_rec1 got pc %h exp 304", bus.out_rec_o[31:0]); end
        tick();
        n_cmp++; if (bus.out_valid_o !== 1'b0) begin n_bad++; $display("FAIL wrap_drained got %b exp 0", bus.out_valid_o); end
    endtask

    task automatic test_reset_mid();
        bus.out_ready_i = 1'b0;
        bus.valid_i     = 3'b111;
        for (int c = 0; c < 5; c++) tick();
        bus.valid_i = 3'b001;
        tick();
        tick();
        bus.valid_i     = 3'b000;
        bus.out_ready_i = 1'b1;
        for (int c = 0; c < 9; c++) tick();
        n_cmp++; if (bus.level_o !== 5'd7) begin n_bad++; $display("FAIL rmid_pre_level got %0d exp 7", bus.level_o); end
        n_cmp++; if (bus.overflow_o !== 1'b1) begin n_bad++; $display("FAIL rmid_pre_overflow got %b exp 1", bus.overflow_o); end
        reset_i     = 1'b1;
        bus.valid_i = 3'b111;
        tick();
        reset_i     = 1'b0;
        bus.valid_i = 3'b000;
        n_cmp++; if (bus.level_o !== 5'd0) begin n_bad++; $display("FAIL rmid_level got %0d exp 0", bus.level_o); end
        n_cmp++; if (bus.out_valid_o !== 1'b0) begin n_bad++; $display("FAIL rmid_out_valid got %b exp 0", bus.out_valid_o); end
        n_cmp++; if (bus.overflow_o !== 1'b0) begin n_bad++; $display("FAIL rmid_overflow got %b exp 0", bus.overflow_o); end
        n_cmp++; if (bus.drop_cnt_o !== 16'd0) begin n_bad++; $display("FAIL rmid_drop got %0d exp 0", bus.drop_cnt_o); end
        bus.out_ready_i = 1'b0;
        bus.valid_i     = 3'b001;
        set_port(0, 32'h500);
        tick();
        bus.valid_i = 3'b000;
        n_cmp++; if (bus.level_o !== 5'd1) begin n_bad++; $display("FAIL rmid_push_level got %0d exp 1", bus.level_o); end
        n_cmp++; if (bus.out_seq_o !== 32'd0) begin n_bad++; $display("FAIL rmid_seq got %0d exp 0", bus.out_seq_o); end
        n_cmp++; if (bus.out_rec_o !== mk_rec(32'h500)) begin n_bad++; $display("FAIL rmid_rec got pc %h exp 500", bus.out_rec_o[31:0]); end
    endtask

`ifdef TRACE_TIMESTAMP_EN
    task automatic test_timestamp();
        bus.out_ready_i = 1'b0;
        bus.valid_i     = 3'b000;
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        for (int c = 0; c < 5; c++) tick();
        bus.valid_i = 3'b001;
        set_port(0, 32'h600);
        tick();
        bus.valid_i = 3'b000;
        for (int c = 0; c < 3; c++) tick();
        bus.valid_i = 3'b001;
        set_port(0, 32'h604);
        tick();
        bus.valid_i = 3'b000;
        n_cmp++; if (bus.out_time_o !== 32'd5) begin n_bad++; $display("FAIL ts_first got %0d exp 5", bus.out_time_o); end
        bus.out_ready_i = 1'b1;
        tick();
        bus.out_ready_i = 1'b0;
        n_cmp++; if (bus.out_time_o !== 32'd9) begin n_bad++; $display("FAIL ts_second got %0d exp 9", bus.out_time_o); end
    endtask
`endif

    initial begin
        n_cmp           = 0;
        n_bad           = 0;
        reset_i         = 1'b1;
        bus.valid_i     = '0;
        bus.rec_i       = '0;
        bus.out_ready_i = 1'b0;
        tick();
        test_reset();
        test_basic();
        test_overflow();
        test_full_pop();
        test_seq_wrap();
        test_reset_mid();
`ifdef TRACE_TIMESTAMP_EN
        test_timestamp();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
